ttt_game_engine: RTL and testbench

TTT_GAME_ENGINE -- requirements
Module: ttt_game_engine

---
 rtl/ttt_game_engine.sv | 197 +++++++++++++++++++
 tb/tb_ttt_game_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_engine.sv
// ---------------------------------------------------------------------------
// ttt_game_engine
//   Referee for an N x N "K in a row" game (tic-tac-toe when N=K=3).
//   The engine accepts one move per handshake and rejects illegal moves with
//   a one-cycle pulse. After each legal move it spends one CHECK cycle looking
//   for a run of K equal marks. It then declares a winner or a draw, or hands
//   the turn to the other player.
//
// Ports
//   clk        : system clock, rising edge active
//   rst_n      : asynchronous active-low reset
//   clear      : synchronous new-game request (highest priority)
//   move_valid : a move is offered on move_row/move_col/move_mark
//   move_ready : engine can take a move this cycle (PLAY and no clear)
//   move_row   : row index of the offered move
//   move_col   : column index of the offered move
//   move_mark  : ASCII "X" or "O" of the offered move
//   turn       : ASCII mark expected next, 8'h00 once the game is over
//   illegal    : one-cycle pulse after a rejected handshake
//   game_over  : high while in DONE
//   winner     : "X", "O", "D" (draw) or 8'h00
//   move_count : number of accepted moves in the current game
//   rd_row     : row index for the combinational board read port
//   rd_col     : column index for the combinational board read port
//   rd_mark    : ASCII mark at (rd_row, rd_col), 8'h00 if empty or off-board
// ---------------------------------------------------------------------------
module ttt_game_engine #(
   parameter int         N     = 3,
   parameter int         K     = 3,
   parameter logic [7:0] FIRST = 8'h58
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         move_valid,
   output logic                         move_ready,
   input  logic [2:0]                   move_row,
   input  logic [2:0]                   move_col,
   input  logic [7:0]                   move_mark,
   output logic [7:0]                   turn,
   output logic                         illegal,
   output logic                         game_over,
   output logic [7:0]                   winner,
   output logic [$clog2(N*N+1)-1:0]     move_count,
   input  logic [2:0]                   rd_row,
   input  logic [2:0]                   rd_col,
   output logic [7:0]                   rd_mark
);

   localparam int CELLS = N * N;
   localparam int IDX_W = $clog2(CELLS);
   localparam int CNT_W = $clog2(CELLS + 1);

   localparam logic [7:0]       MARK_X = 8'h58;
   localparam logic [7:0]       MARK_O = 8'h4F;
   localparam logic [7:0]       MARK_D = 8'h44;
   localparam logic [2:0]       SIDE   = 3'(N);
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(CELLS);

   localparam logic [1:0] PLAY  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   // Each cell is a 2-bit code: 00 empty, 01 X, 10 O.
   logic [CELLS-1:0][1:0] board;
   logic [1:0]            state;
   logic                  run_found;
   logic                  move_in_range;
   logic                  move_legal;
   logic [IDX_W-1:0]      move_idx;
   logic                  rd_in_range;
   logic [IDX_W-1:0]      rd_idx;

   function automatic logic [1:0] enc(input logic [7:0] mark);
      return (mark == MARK_X) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [7:0] dec(input logic [1:0] code);
      case (code)
         2'b01:   return MARK_X;
         2'b10:   return MARK_O;
         default: return 8'h00;
      endcase
   endfunction

   // Row-major linear index; callers only use it for on-board coordinates.
   function automatic logic [IDX_W-1:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
      logic [5:0] lin;
      lin = {3'b000, r} * 6'(N) + {3'b000, c};
      return IDX_W'(lin);
   endfunction

   // True when K cells starting at (r,c) and stepping by (dr,dc) all lie on
   // the board, are non-empty, and hold the same mark.
   function automatic logic run_from(input logic [CELLS-1:0][1:0] b,
                                     input int r, input int c,
                                     input int dr, input int dc);
      logic       hit;
      logic [1:0] lead;
      int         er;
      int         ec;
      hit  = 1'b0;
      lead = 2'b00;
      er   = r + (K - 1) * dr;
      ec   = c + (K - 1) * dc;
      if (er >= 0 && er < N && ec >= 0 && ec < N) begin
         lead = b[IDX_W'(r * N + c)];
         hit  = (lead != 2'b00);
         for (int i = 1; i < K; i++) begin
            if (b[IDX_W'((r + i * dr) * N + (c + i * dc))] != lead) hit = 1'b0;
         end
      end
      return hit;
   endfunction

   // Whole-board scan: every cell is tried as the start of a horizontal,
   // vertical, diagonal and anti-diagonal run.
   always_comb begin
      run_found = 1'b0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (run_from(board, r, c, 0, 1) || run_from(board, r, c, 1, 0) ||
                run_from(board, r, c, 1, 1) || run_from(board, r, c, 1, -1))
               run_found = 1'b1;
         end
      end
   end

   assign move_ready    = (state == PLAY) && !clear;
   assign move_in_range = (move_row < SIDE) && (move_col < SIDE);
   assign move_idx      = move_in_range ? cell_idx(move_row, move_col) : '0;
   assign move_legal    = move_in_range && (board[move_idx] == 2'b00) && (move_mark == turn);

   assign rd_in_range = (rd_row < SIDE) && (rd_col < SIDE);
   assign rd_idx      = rd_in_range ? cell_idx(rd_row, rd_col) : '0;
   assign rd_mark     = rd_in_range ? dec(board[rd_idx]) : 8'h00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= PLAY;
         board      <= '0;
         move_count <= '0;
         turn       <= FIRST;
         winner     <= 8'h00;
         game_over  <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         illegal <= 1'b0;
         if (clear) begin
            state      <= PLAY;
            board      <= '0;
            move_count <= '0;
            turn       <= FIRST;
            winner     <= 8'h00;
            game_over  <= 1'b0;
         end else begin
            case (state)
               PLAY: begin
                  if (move_valid) begin
                     if (move_legal) begin
                        board[move_idx] <= enc(move_mark);
                        move_count      <= move_count + CNT_W'(1);
                        state           <= CHECK;
                     end else begin
                        illegal <= 1'b1;
                     end
                  end
               end
               CHECK: begin
                  // turn still holds the mark just placed, so it names the winner.
                  if (run_found) begin
                     winner    <= turn;
                     game_over <= 1'b1;
                     turn      <= 8'h00;
                     state     <= DONE;
                  end else if (move_count == FULL) begin
                     winner    <= MARK_D;
                     game_over <= 1'b1;
                     turn      <= 8'h00;
                     state     <= DONE;
                  end else begin
                     turn  <= (turn == MARK_X) ? MARK_O : MARK_X;
                     state <= PLAY;
                  end
               end
               DONE: begin
                  state <= DONE;
               end
               default: begin
                  state <= PLAY;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ttt_game_engine.sv
module tb_ttt_game_engine;

   localparam logic [7:0] MX = 8'h58;
   localparam logic [7:0] MO = 8'h4F;
   localparam logic [7:0] MD = 8'h44;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       move_valid = 1'b0;
   logic [2:0] move_row = 3'd0;
   logic [2:0] move_col = 3'd0;
   logic [7:0] move_mark = 8'h00;
   logic [2:0] rd_row = 3'd0;
   logic [2:0] rd_col = 3'd0;

   logic       ready3, ill3, go3;
   logic [7:0] turn3, win3, rdm3;
   logic [3:0] cnt3;
   logic       ready5, ill5, go5;
   logic [7:0] turn5, win5, rdm5;
   logic [4:0] cnt5;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic       rdy;
      logic       ill;
      logic       ill2;
      logic [7:0] win;
      logic       go;
      logic [7:0] trn;
      logic [4:0] cnt;
   } res_t;

   res_t exp_q[$];
   res_t obs_q[$];

   ttt_game_engine #(.N(3), .K(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .move_valid(move_valid),
      .move_ready(ready3), .move_row(move_row), .move_col(move_col),
      .move_mark(move_mark), .turn(turn3), .illegal(ill3), .game_over(go3),
      .winner(win3), .move_count(cnt3), .rd_row(rd_row), .rd_col(rd_col),
      .rd_mark(rdm3)
   );

   ttt_game_engine #(.N(5), .K(4)) dut5 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .move_valid(move_valid),
      .move_ready(ready5), .move_row(move_row), .move_col(move_col),
      .move_mark(move_mark), .turn(turn5), .illegal(ill5), .game_over(go5),
      .winner(win5), .move_count(cnt5), .rd_row(rd_row), .rd_col(rd_col),
      .rd_mark(rdm5)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached (got no finish, want finish)");
      $fatal(1, "watchdog expired");
   end

   // Offers one move, records the expected outcome and what the selected DUT
   // shows: #1 after the handshake edge and #1 after the following edge.
   task automatic move(input bit use5, input logic [2:0] r, input logic [2:0] c,
                       input logic [7:0] m, input logic e_ill, input logic [7:0] e_win,
                       input logic [7:0] e_trn, input logic [4:0] e_cnt);
      res_t e;
      res_t o;
      e.rdy  = e_ill;
      e.ill  = e_ill;
      e.ill2 = 1'b0;
      e.win  = e_win;
      e.go   = (e_win != 8'h00);
      e.trn  = e_trn;
      e.cnt  = e_cnt;
      exp_q.push_back(e);
      @(negedge clk);
      move_valid = 1'b1;
      move_row   = r;
      move_col   = c;
      move_mark  = m;
      @(posedge clk);
      #1;
      move_valid = 1'b0;
      o.rdy = use5 ? ready5 : ready3;
      o.ill = use5 ? ill5 : ill3;
      @(posedge clk);
      #1;
      o.ill2 = use5 ? ill5 : ill3;
      o.win  = use5 ? win5 : win3;
      o.go   = use5 ? go5 : go3;
      o.trn  = use5 ? turn5 : turn3;
      o.cnt  = use5 ? cnt5 : {1'b0, cnt3};
      obs_q.push_back(o);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rd_row = 3'd0;
      rd_col = 3'd0;
      repeat (2) @(negedge clk);
      n_cmp++; if (ready3 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready3); end
      n_cmp++; if (turn3 !== MX) begin n_err++; $display("FAIL reset_turn: got %h want %h", turn3, MX); end
      n_cmp++; if (win3 !== 8'h00) begin n_err++; $display("FAIL reset_winner: got %h want 00", win3); end
      n_cmp++; if (go3 !== 1'b0) begin n_err++; $display("FAIL reset_game_over: got %b want 0", go3); end
      n_cmp++; if (ill3 !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b want 0", ill3); end
      n_cmp++; if (cnt3 !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cnt3); end
      n_cmp++; if (rdm3 !== 8'h00) begin n_err++; $display("FAIL reset_board: got %h want 00", rdm3); end
      n_cmp++; if (turn5 !== MX || ready5 !== 1'b1) begin n_err++; $display("FAIL reset_dut5: got turn=%h ready=%b want turn=%h ready=1", turn5, ready5, MX); end
      rst_n = 1'b1;
   endtask

   task automatic test_x_win();
      res_t e;
      res_t o;
      int   k;
      move(0, 3'd0, 3'd0, MX, 1'b0, 8'h00, MO, 5'd1);
      move(0, 3'd1, 3'd0, MO, 1'b0, 8'h00, MX, 5'd2);
      move(0, 3'd0, 3'd1, MX, 1'b0, 8'h00, MO, 5'd3);
      move(0, 3'd1, 3'd1, MO, 1'b0, 8'h00, MX, 5'd4);
      move(0, 3'd0, 3'd2, MX, 1'b0, MX, 8'h00, 5'd5);
      // offered in DONE: no handshake, everything held
      move(0, 3'd2, 3'd2, MO, 1'b0, MX, 8'h00, 5'd5);
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL x_win move %0d: got rdy=%b ill=%b/%b win=%h go=%b turn=%h cnt=%0d want rdy=%b ill=%b/%b win=%h go=%b turn=%h cnt=%0d",
                     k, o.rdy, o.ill, o.ill2, o.win, o.go, o.trn, o.cnt, e.rdy, e.ill, e.ill2, e.win, e.go, e.trn, e.cnt);
         end
         k++;
      end
      rd_row = 3'd0;
      rd_col = 3'd2;
      #1;
      n_cmp++; if (rdm3 !== MX) begin n_err++; $display("FAIL x_win_read: got %h want %h", rdm3, MX); end
      n_cmp++; if (ready3 !== 1'b0) begin n_err++; $display("FAIL x_win_done_ready: got %b want 0", ready3); end
   endtask

   task automatic test_clear();
      // clear while in DONE
      @(negedge clk);
      clear = 1'b1;
      #1;
      n_cmp++; if (ready3 !== 1'b0) begin n_err++; $display("FAIL clear_ready_low: got %b want 0", ready3); end
      @(posedge clk);
      #1;
      clear  = 1'b0;
      rd_row = 3'd0;
      rd_col = 3'd0;
      #1;
      n_cmp++; if (go3 !== 1'b0 || win3 !== 8'h00) begin n_err++; $display("FAIL clear_done: got go=%b win=%h want go=0 win=00", go3, win3); end
      n_cmp++; if (turn3 !== MX || cnt3 !== 4'd0) begin n_err++; $display("FAIL clear_done_turn: got turn=%h cnt=%0d want turn=%h cnt=0", turn3, cnt3, MX); end
      n_cmp++; if (rdm3 !== 8'h00) begin n_err++; $display("FAIL clear_done_board: got %h want 00", rdm3); end
      n_cmp++; if (ready3 !== 1'b1) begin n_err++; $display("FAIL clear_done_ready: got %b want 1", ready3); end
      // clear together with a valid move
      @(negedge clk);
      clear      = 1'b1;
      move_valid = 1'b1;
      move_row   = 3'd1;
      move_col   = 3'd1;
      move_mark  = MX;
      @(posedge clk);
      #1;
      clear      = 1'b0;
      move_valid = 1'b0;
      rd_row     = 3'd1;
      rd_col     = 3'd1;
      #1;
      n_cmp++; if (cnt3 !== 4'd0 || rdm3 !== 8'h00) begin n_err++; $display("FAIL clear_vs_move: got cnt=%0d cell=%h want cnt=0 cell=00", cnt3, rdm3); end
      n_cmp++; if (turn3 !== MX || ill3 !== 1'b0) begin n_err++; $display("FAIL clear_vs_move_turn: got turn=%h ill=%b want turn=%h ill=0", turn3, ill3, MX); end
      // clear during the CHECK cycle of a legal move
      @(negedge clk);
      move_valid = 1'b1;
      move_row   = 3'd2;
      move_col   = 3'd2;
      move_mark  = MX;
      @(posedge clk);
      #1;
      move_valid = 1'b0;
      clear      = 1'b1;
      @(posedge clk);
      #1;
      clear  = 1'b0;
      rd_row = 3'd2;
      rd_col = 3'd2;
      #1;
      n_cmp++; if (turn3 !== MX || cnt3 !== 4'd0 || rdm3 !== 8'h00) begin n_err++; $display("FAIL clear_in_check: got turn=%h cnt=%0d cell=%h want turn=%h cnt=0 cell=00", turn3, cnt3, rdm3, MX); end
      n_cmp++; if (ready3 !== 1'b1 || go3 !== 1'b0) begin n_err++; $display("FAIL clear_in_check_ready: got ready=%b go=%b want ready=1 go=0", ready3, go3); end
   endtask

   task automatic test_draw();
      res_t e;
      res_t o;
      int   k;
      do_clear();
      move(0, 3'd0, 3'd0, MX, 1'b0, 8'h00, MO, 5'd1);
      move(0, 3'd0, 3'd1, MO, 1'b0, 8'h00, MX, 5'd2);
      move(0, 3'd0, 3'd2, MX, 1'b0, 8'h00, MO, 5'd3);
      move(0, 3'd1, 3'd1, MO, 1'b0, 8'h00, MX, 5'd4);
      move(0, 3'd1, 3'd0, MX, 1'b0, 8'h00, MO, 5'd5);
      move(0, 3'd1, 3'd2, MO, 1'b0, 8'h00, MX, 5'd6);
      move(0, 3'd2, 3'd1, MX, 1'b0, 8'h00, MO, 5'd7);
      move(0, 3'd2, 3'd0, MO, 1'b0, 8'h00, MX, 5'd8);
      move(0, 3'd2, 3'd2, MX, 1'b0, MD, 8'h00, 5'd9);
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL draw move %0d: got rdy=%b ill=%b/%b win=%h go=%b turn=%h cnt=%0d want rdy=%b ill=%b/%b win=%h go=%b turn=%h cnt=%0d",
                     k, o.rdy, o.ill, o.ill2, o.win, o.go, o.trn, o.cnt, e.rdy, e.ill, e.ill2, e.win, e.go, e.trn, e.cnt);
         end
         k++;
      end
   endtask

   task automatic test_illegal();
      res_t e;
      res_t o;
      int   k;
      do_clear();
      move(0, 3'd1, 3'd1, MX, 1'b0, 8'h00, MO, 5'd1);
      move(0, 3'd1, 3'd1, MO, 1'b1, 8'h00, MO, 5'd1);  // occupied
      move(0, 3'd3, 3'd0, MO, 1'b1, 8'h00, MO, 5'd1);  // row off-board
      move(0, 3'd0, 3'd0, MX, 1'b1, 8'h00, MO, 5'd1);  // wrong mark
      move(0, 3'd0, 3'd3, MO, 1'b1, 8'h00, MO, 5'd1);  // column off-board
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL illegal move %0d: got rdy=%b ill=%b/%b win=%h go=%b turn=%h cnt=%0d want rdy=%b ill=%b/%b win=%h go=%b turn=%h cnt=%0d",
                     k, o.rdy, o.ill, o.ill2, o.win, o.go, o.trn, o.cnt, e.rdy, e.ill, e.ill2, e.win, e.go, e.trn, e.cnt);
         end
         k++;
      end
      rd_row = 3'd1;
      rd_col = 3'd1;
      #1;
      n_cmp++; if (rdm3 !== MX) begin n_err++; $display("FAIL illegal_read_11: got %h want %h", rdm3, MX); end
      rd_row = 3'd0;
      rd_col = 3'd0;
      #1;
      n_cmp++; if (rdm3 !== 8'h00) begin n_err++; $display("FAIL illegal_read_00: got %h want 00", rdm3); end
      rd_row = 3'd3;
      rd_col = 3'd0;
      #1;
      n_cmp++; if (rdm3 !== 8'h00) begin n_err++; $display("FAIL read_off_board: got %h want 00", rdm3); end
   endtask

   task automatic test_anti_diag5();
      res_t e;
      res_t o;
      int   k;
      do_clear();
      move(1, 3'd0, 3'd0, MX, 1'b0, 8'h00, MO, 5'd1);
      move(1, 3'd0, 3'd4, MO, 1'b0, 8'h00, MX, 5'd2);
      move(1, 3'd0, 3'd1, MX, 1'b0, 8'h00, MO, 5'd3);
      move(1, 3'd1, 3'd3, MO, 1'b0, 8'h00, MX, 5'd4);
      move(1, 3'd4, 3'd4, MX, 1'b0, 8'h00, MO, 5'd5);
      move(1, 3'd2, 3'd2, MO, 1'b0, 8'h00, MX, 5'd6);  // K-1 in a row: no win
      move(1, 3'd4, 3'd3, MX, 1'b0, 8'h00, MO, 5'd7);
      move(1, 3'd3, 3'd1, MO, 1'b0, MO, 8'h00, 5'd8);
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL anti_diag5 move %0d: got rdy=%b ill=%b/%b win=%h go=%b turn=%h cnt=%0d want rdy=%b ill=%b/%b win=%h go=%b turn=%h cnt=%0d",
                     k, o.rdy, o.ill, o.ill2, o.win, o.go, o.trn, o.cnt, e.rdy, e.ill, e.ill2, e.win, e.go, e.trn, e.cnt);
         end
         k++;
      end
      rd_row = 3'd4;
      rd_col = 3'd4;
      #1;
      n_cmp++; if (rdm5 !== MX) begin n_err++; $display("FAIL anti_diag5_read: got %h want %h", rdm5, MX); end
   endtask

   task automatic test_reset_mid_check();
      res_t e;
      res_t o;
      int   k;
      do_clear();
      move(0, 3'd0, 3'd0, MX, 1'b0, 8'h00, MO, 5'd1);
      move(0, 3'd1, 3'd0, MO, 1'b0, 8'h00, MX, 5'd2);
      move(0, 3'd0, 3'd1, MX, 1'b0, 8'h00, MO, 5'd3);
      move(0, 3'd1, 3'd1, MO, 1'b0, 8'h00, MX, 5'd4);
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL mid_check_setup move %0d: got rdy=%b ill=%b/%b win=%h go=%b turn=%h cnt=%0d want rdy=%b ill=%b/%b win=%h go=%b turn=%h cnt=%0d",
                     k, o.rdy, o.ill, o.ill2, o.win, o.go, o.trn, o.cnt, e.rdy, e.ill, e.ill2, e.win, e.go, e.trn, e.cnt);
         end
         k++;
      end
      rd_row = 3'd0;
      rd_col = 3'd0;
      // winning move, then reset pulsed inside its CHECK cycle
      @(negedge clk);
      move_valid = 1'b1;
      move_row   = 3'd0;
      move_col   = 3'd2;
      move_mark  = MX;
      @(posedge clk);
      #1;
      move_valid = 1'b0;
      n_cmp++; if (ready3 !== 1'b0 || cnt3 !== 4'd5) begin n_err++; $display("FAIL mid_check_entry: got ready=%b cnt=%0d want ready=0 cnt=5", ready3, cnt3); end
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (turn3 !== MX || win3 !== 8'h00 || go3 !== 1'b0) begin n_err++; $display("FAIL async_reset_outputs: got turn=%h win=%h go=%b want turn=%h win=00 go=0", turn3, win3, go3, MX); end
      n_cmp++; if (cnt3 !== 4'd0 || ill3 !== 1'b0 || ready3 !== 1'b1) begin n_err++; $display("FAIL async_reset_ctrl: got cnt=%0d ill=%b ready=%b want cnt=0 ill=0 ready=1", cnt3, ill3, ready3); end
      n_cmp++; if (rdm3 !== 8'h00) begin n_err++; $display("FAIL async_reset_board: got %h want 00", rdm3); end
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (win3 !== 8'h00 || go3 !== 1'b0) begin n_err++; $display("FAIL after_reset_winner: got win=%h go=%b want win=00 go=0", win3, go3); end
      n_cmp++; if (turn3 !== MX || cnt3 !== 4'd0 || ready3 !== 1'b1) begin n_err++; $display("FAIL after_reset_state: got turn=%h cnt=%0d ready=%b want turn=%h cnt=0 ready=1", turn3, cnt3, ready3, MX); end
   endtask

   initial begin
      test_reset();
      test_x_win();
      test_clear();
      test_draw();
      test_illegal();
      test_anti_diag5();
      test_reset_mid_check();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
